// File: rtl/e_clk_window_gen.sv
// E-clock bus-buffer enable generator: N_CH programmable windows timed from the 6809 E clock,
// plus E-period measurement and stuck-E watchdog. Define E_CLK_SYNC_EN for a 2-flop input synchroniser.
module e_clk_window_gen #(
  parameter int                      N_CH      = 2,
  parameter int                      CNT_W     = 7,
  parameter logic [N_CH*CNT_W-1:0]   START_VEC = {7'd44, 7'd0},
  parameter logic [N_CH*CNT_W-1:0]   HOLD_VEC  = {7'd4, 7'd4},
  parameter logic [N_CH-1:0]         POL_MASK  = 2'b00,
  parameter int                      PER_W     = 10,
  parameter int                      TIMEOUT   = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_e_clk,
  output logic [N_CH-1:0]   o_win,
  output logic              o_e_rise,
  output logic              o_e_fall,
  output logic [PER_W-1:0]  o_period,
  output logic              o_period_vld,
  output logic              o_e_stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] WD_LAST = PER_W'(TIMEOUT - 1);
`ifdef E_CLK_SYNC_EN
  localparam int PRIME = 4;
`else
  localparam int PRIME = 2;
`endif

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PER_W-1:0] sat_per(input logic [PER_W-1:0] v);
    return (v == PER_MAX) ? v : v + PER_W'(1);
  endfunction

  logic             e_in;
  logic             e_q;
  logic             e_prev;
  logic [PRIME-1:0] rdy_p;
  logic             edge_ok;
  logic             rise;
  logic             fall;
  logic             armed;
  logic             armed_nxt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] l_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] l_nxt;
  logic [N_CH-1:0]  win_nxt;
  logic [N_CH-1:0]  win_raw;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] wd_cnt;

  // Stage p0: optional synchroniser ahead of the sampling register
`ifdef E_CLK_SYNC_EN
  logic e_s1_p0;
  logic e_s2_p0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      e_s1_p0 <= 1'b0;
      e_s2_p0 <= 1'b0;
    end else begin
      e_s1_p0 <= i_e_clk;
      e_s2_p0 <= e_s1_p0;
    end
  end

  assign e_in = e_s2_p0;
`else
  assign e_in = i_e_clk;
`endif

  // Stage p1: E sample, previous sample, and priming of the edge detector
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      e_q    <= 1'b0;
      e_prev <= 1'b1;
      rdy_p  <= '0;
    end else begin
      e_q    <= e_in;
      e_prev <= e_q;
      rdy_p  <= {rdy_p[PRIME-2:0], 1'b1};
    end
  end

  // Edges are only trusted once both e_q and e_prev hold real post-reset samples,
  // so the reset values of the sample chain never look like an E transition.
  assign edge_ok = rdy_p[PRIME-1];

  always_comb begin
    rise      = edge_ok & e_q & ~e_prev;
    fall      = edge_ok & ~e_q & e_prev;
    armed_nxt = armed | rise;

    if (rise)      h_nxt = CNT_W'(1);
    else if (e_q)  h_nxt = sat_cnt(h_cnt);
    else           h_nxt = '0;

    if (fall)      l_nxt = CNT_W'(1);
    else if (!e_q) l_nxt = sat_cnt(l_cnt);
    else           l_nxt = '0;

    win_nxt = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (e_q) win_nxt[k] = armed_nxt & (h_nxt >  START_VEC[k*CNT_W +: CNT_W]);
      else     win_nxt[k] = armed_nxt & (l_nxt <= HOLD_VEC[k*CNT_W +: CNT_W]);
    end
  end

  // Stage p2: phase counters, windows and edge pulses
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      armed    <= 1'b0;
      h_cnt    <= '0;
      l_cnt    <= '0;
      win_raw  <= '0;
      o_e_rise <= 1'b0;
      o_e_fall <= 1'b0;
    end else begin
      armed    <= armed_nxt;
      h_cnt    <= h_nxt;
      l_cnt    <= l_nxt;
      win_raw  <= win_nxt;
      o_e_rise <= rise;
      o_e_fall <= fall;
    end
  end

  assign o_win = win_raw ^ POL_MASK;

  // Stage p2: period measurement and stuck-E watchdog
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      per_cnt      <= '0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
      wd_cnt       <= '0;
      o_e_stuck    <= 1'b0;
    end else begin
      o_period_vld <= 1'b0;
      if (rise) begin
        per_cnt <= '0;
        // The first rise after reset only starts the measurement.
        if (armed) begin
          o_period     <= sat_per(per_cnt);
          o_period_vld <= 1'b1;
        end
      end else begin
        per_cnt <= sat_per(per_cnt);
      end

      if (rise || fall) begin
        wd_cnt    <= '0;
        o_e_stuck <= 1'b0;
      end else begin
        wd_cnt <= sat_per(wd_cnt);
        if (wd_cnt == WD_LAST) o_e_stuck <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_e_clk_window_gen.sv
// Randomised bench for e_clk_window_gen: three parameterisations share one E stimulus and are
// compared every cycle against a timestamp-based reference model.
module tb_e_clk_window_gen;

  localparam int NI = 3;
`ifdef E_CLK_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       e_clk;
  logic [1:0] win_a, win_b, win_c;
  logic       rise_a, rise_b, rise_c;
  logic       fall_a, fall_b, fall_c;
  logic [9:0] per_a, per_b;
  logic [5:0] per_c;
  logic       vld_a, vld_b, vld_c;
  logic       stk_a, stk_b, stk_c;

  e_clk_window_gen u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_e_clk(e_clk),
    .o_win(win_a), .o_e_rise(rise_a), .o_e_fall(fall_a),
    .o_period(per_a), .o_period_vld(vld_a), .o_e_stuck(stk_a)
  );

  e_clk_window_gen #(.POL_MASK(2'b11), .TIMEOUT(50)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_e_clk(e_clk),
    .o_win(win_b), .o_e_rise(rise_b), .o_e_fall(fall_b),
    .o_period(per_b), .o_period_vld(vld_b), .o_e_stuck(stk_b)
  );

  e_clk_window_gen #(
    .CNT_W(3), .START_VEC({3'd7, 3'd2}), .HOLD_VEC({3'd7, 3'd0}),
    .PER_W(6), .TIMEOUT(40)
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_e_clk(e_clk),
    .o_win(win_c), .o_e_rise(rise_c), .o_e_fall(fall_c),
    .o_period(per_c), .o_period_vld(vld_c), .o_e_stuck(stk_c)
  );

  int st [NI][2];
  int hd [NI][2];
  int pol [NI];
  int cmax [NI];
  int pmax [NI];
  int tmo [NI];

  bit armed [NI];
  int t_rise [NI];
  int t_fall [NI];
  int anchor [NI];
  int ex_win [NI];
  int ex_edge [NI];
  int ex_per [NI];
  int ex_vld [NI];
  int ex_stk [NI];
  bit sq [$];

  int cyc   = 0;
  int n_chk = 0;
  int n_bad = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: windows from time since the last rise/fall, period from rise timestamps,
  // watchdog from time since the last edge (or reset release).
  task automatic model_step(input logic rv, input logic ev);
    bit ok, eq, ep, rs, fl;
    int h, l, w;
    ok = rv && (sq.size() >= D + 2);
    eq = (sq.size() >= D + 1) ? sq[sq.size() - 1 - D] : 1'b0;
    ep = ok ? sq[sq.size() - 2 - D] : 1'b0;
    rs = ok && eq && !ep;
    fl = ok && !eq && ep;
    for (int i = 0; i < NI; i++) begin
      if (!rv) begin
        armed[i]   = 1'b0;
        ex_win[i]  = 0;
        ex_edge[i] = 0;
        ex_per[i]  = 0;
        ex_vld[i]  = 0;
        ex_stk[i]  = 0;
        anchor[i]  = cyc + 1;
      end else begin
        ex_edge[i] = (rs ? 2 : 0) + (fl ? 1 : 0);
        ex_vld[i]  = 0;
        if (rs) begin
          if (armed[i]) begin
            ex_per[i] = imin(cyc - t_rise[i], pmax[i]);
            ex_vld[i] = 1;
          end
          t_rise[i] = cyc;
          armed[i]  = 1'b1;
        end
        if (fl) t_fall[i] = cyc;
        ex_stk[i] = (!(rs || fl) && (cyc - anchor[i] >= tmo[i] - 1)) ? 1 : 0;
        if (rs || fl) anchor[i] = cyc + 1;
        w = 0;
        for (int k = 0; k < 2; k++) begin
          h = imin(cyc - t_rise[i] + 1, cmax[i]);
          l = imin(cyc - t_fall[i] + 1, cmax[i]);
          if (armed[i] && (eq ? (h > st[i][k]) : (l <= hd[i][k]))) w |= (1 << k);
        end
        ex_win[i] = w;
      end
      ex_win[i] ^= pol[i];
    end
    if (!rv) sq.delete();
    else begin
      sq.push_back(ev);
      if (sq.size() > 8) void'(sq.pop_front());
    end
    cyc++;
  endtask

  task automatic check_inst(input int i, input string nm, input logic [1:0] w, input logic r,
                            input logic f, input logic [9:0] p, input logic v, input logic s);
    check_val({nm, ".win"},  32'(w),        32'(ex_win[i]));
    check_val({nm, ".edge"}, 32'({r, f}),   32'(ex_edge[i]));
    check_val({nm, ".per"},  32'({v, p}),   32'(ex_vld[i] * 1024 + ex_per[i]));
    check_val({nm, ".stk"},  32'(s),        32'(ex_stk[i]));
  endtask

  task automatic tick(input logic rv, input logic ev);
    rst_n = rv;
    e_clk = ev;
    @(posedge clk);
    model_step(rv, ev);
    #1;
    check_inst(0, "a", win_a, rise_a, fall_a, per_a, vld_a, stk_a);
    check_inst(1, "b", win_b, rise_b, fall_b, per_b, vld_b, stk_b);
    check_inst(2, "c", win_c, rise_c, fall_c, {4'd0, per_c}, vld_c, stk_c);
  endtask

  task automatic phase(input logic ev, input int len);
    repeat (len) tick(1'b1, ev);
  endtask

  initial begin
    logic lvl;
    st[0] = '{0, 44}; hd[0] = '{4, 4}; pol[0] = 0; cmax[0] = 127; pmax[0] = 1023; tmo[0] = 1000;
    st[1] = '{0, 44}; hd[1] = '{4, 4}; pol[1] = 3; cmax[1] = 127; pmax[1] = 1023; tmo[1] = 50;
    st[2] = '{2, 7};  hd[2] = '{0, 7}; pol[2] = 0; cmax[2] = 7;   pmax[2] = 63;   tmo[2] = 40;
    for (int i = 0; i < NI; i++) begin
      armed[i] = 1'b0; t_rise[i] = 0; t_fall[i] = 0; anchor[i] = 0;
    end

    // Reset values, then E idle low (inverted-polarity channels sit high)
    repeat (3) tick(1'b0, 1'b0);
    phase(1'b0, 20);

    // E high through reset release and left high: no rise, watchdog fires
    repeat (2) tick(1'b0, 1'b1);
    phase(1'b1, 1010);

    // 100-cycle period, 50/50 duty
    for (int p = 0; p < 4; p++) begin
      phase(1'b0, 50);
      phase(1'b1, 50);
    end
    phase(1'b0, 50);

    // Short high phase: START=44 channel only shows its hold tail
    for (int p = 0; p < 3; p++) begin
      phase(1'b1, 20);
      phase(1'b0, 30);
    end

    // Long high phase against the small-counter instance
    for (int p = 0; p < 2; p++) begin
      phase(1'b1, 30);
      phase(1'b0, 10);
    end

    // Reset mid high-phase with windows open
    phase(1'b1, 40);
    tick(1'b0, 1'b1);
    phase(1'b1, 10);
    phase(1'b0, 50);
    for (int p = 0; p < 3; p++) begin
      phase(1'b1, 50);
      phase(1'b0, 50);
    end

    // Random phase lengths, including single-cycle phases
    lvl = 1'b1;
    for (int p = 0; p < 40; p++) begin
      phase(lvl, int'($urandom_range(120, 1)));
      lvl = ~lvl;
    end

    // Long stall low, then recovery
    phase(1'b0, 1100);
    phase(1'b1, 30);
    phase(1'b0, 30);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
